div_iter: RTL and testbench
===========================

# div_iter

Parametrised multi-cycle integer divider: the sequential successor to the fixed-width pipelined restoring slice chain. It reuses one restoring-subtract step per clock to cut area, adds signed and unsigned modes, and returns both quotient and remainder. It flags divide-by-zero and signed overflow. It sits behind a valid/ready handshake in the datapath, as a shared divider for the ALU or for a peripheral.

## Interface
- DATA_W, 32: operand and result width; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept; high only in IDLE.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- dividend  in  DATA_W  numerator.
- divisor  in  DATA_W  denominator.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- quotient  out  DATA_W  result quotient.
- remainder  out  DATA_W  result remainder.
- div_zero  out  1  divisor was zero.
- overflow  out  1  signed most-negative / −1.

## Operation
- FSM states and transitions:
  - IDLE → CALC on in_valid & in_ready.
  - CALC → FIX when the step counter reaches 0.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
- Accept (IDLE):
  - Latch sign_q = in_signed & (dividend[MSB] ^ divisor[MSB]) and sign_r = in_signed & dividend[MSB].
  - Latch magnitudes |dividend| and |divisor|; take the magnitude only when in_signed is high.
  - Latch the original dividend, the zero-divisor condition and the overflow condition.
  - Load counter = DATA_W−1.
- CALC, one restoring step per cycle:
  - partial remainder (DATA_W+1 bits) = {rem[DATA_W−1:0], next dividend bit}.
  - Trial subtract the divisor magnitude.
  - If the trial result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the partial remainder and shift in 0.
  - All arithmetic is unsigned, DATA_W+1 bits wide.
- FIX:
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Override on zero divisor: quotient = all ones, remainder = original dividend, div_zero = 1. The override applies in both modes.
  - Overflow (signed, dividend = 100…0, divisor = all ones): quotient = 100…0, remainder = 0, overflow = 1. The natural datapath result already equals this; the flag is the only added logic.
  - Unsigned mode never sets overflow.
- DONE:
  - out_valid = 1; quotient, remainder and flags stay stable until out_ready.
  - No new input is accepted in DONE.
- Reset values:
  - in_ready = 1 (state IDLE); out_valid = 0.
  - quotient, remainder, div_zero and overflow = 0.
  - All internal registers = 0.
- Reset asserted mid-operation aborts the operation immediately; no result is produced.

## Timing
- Accept edge = T0. CALC occupies edges T1…T_DATA_W, FIX is edge T_DATA_W+1, and out_valid rises after edge T_DATA_W+1. This is a fixed latency of DATA_W+1 cycles, independent of operands, mode and flags.
- in_ready drops the cycle after acceptance. It returns the cycle after the out_valid & out_ready edge.
- Minimum initiation interval is DATA_W+3 cycles.
- in_valid while busy is ignored. Operands need to be stable only in the accept cycle.
- out_valid & out_ready in the same cycle as in_valid does not give same-cycle re-accept; acceptance happens the next cycle.

## Structure
- Package div_pkg holds:
  - the state enum: IDLE, CALC, FIX, DONE;
  - the counter-width function clog2(DATA_W);
  - a magnitude helper function.
- Sub-module div_step is a combinational single restoring step, parametrised by DATA_W.
  - Inputs: partial remainder, divisor, incoming bit.
  - Outputs: next remainder and quotient bit.
  - It is reusable for a future unrolled variant (several steps per cycle).

## Test plan
Default DATA_W = 8 unless noted.
- Unsigned 200 / 7: quotient = 28, remainder = 4, flags 0. out_valid is exactly 9 cycles after accept.
- Signed −7 / 2 (0xF9 / 0x02): quotient = 0xFD (−3), remainder = 0xFF (−1). Signed 7 / −2: quotient = 0xFD, remainder = 0x01.
- Signed −5 / 0: quotient = 0xFF, remainder = 0xFB, div_zero = 1. Unsigned 9 / 0: quotient = 0xFF, remainder = 0x09, div_zero = 1.
- Signed −128 / −1 (0x80 / 0xFF): quotient = 0x80, remainder = 0, overflow = 1. Same operands unsigned: quotient = 0, remainder = 0x80, overflow = 0.
- Backpressure: hold out_ready low 5 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - in_valid pulses during the wait are ignored.
  - After release, in_ready = 1 next cycle.
- Reset and sweep:
  - Assert rst_n low at CALC step 3 → all outputs at reset values, in_ready = 1 after release, no spurious out_valid.
  - Random back-to-back sweep with DATA_W = 32 and DATA_W = 5 against a reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand the magnitude helper handles.
  localparam int MAG_MAX_W = 64;

  // Bits needed to count from n-1 down to 0 (at least 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Two's-complement magnitude when neg is set; callers truncate to their width.
  function automatic logic [MAG_MAX_W-1:0] magnitude(input logic [MAG_MAX_W-1:0] v,
                                                     input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] divisor,
  input  logic              bit_in,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] trial;

  // rem_in < divisor always holds, so the DATA_W+1 bit difference MSB is a valid sign.
  always_comb begin
    partial = {rem_in, bit_in};
    trial   = partial - {1'b0, divisor};
    q_bit   = ~trial[DATA_W];
    rem_out = q_bit ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned restoring divider behind a valid/ready handshake.
// One quotient bit per cycle; fixed latency of DATA_W+1 cycles from accept to out_valid.
// Operand width is limited to div_pkg::MAG_MAX_W bits by the magnitude helper.
module div_iter
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero,
  output logic              overflow
);

  localparam int                CNT_W    = clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;
  logic   accept, step_en, fix_en;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd_sh;    // dividend bits shift out the top, quotient bits shift in below
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dsr_mag;
  logic [DATA_W-1:0] dvd_orig;
  logic              sign_q, sign_r, zero_q, ovf_q;

  logic [DATA_W-1:0] dvd_mag, dsr_mag_in;
  logic [DATA_W-1:0] rem_nxt;
  logic              q_bit;

  // Operand magnitudes are only taken in signed mode.
  always_comb begin
    dvd_mag    = DATA_W'(magnitude(MAG_MAX_W'(dividend), in_signed & dividend[DATA_W-1]));
    dsr_mag_in = DATA_W'(magnitude(MAG_MAX_W'(divisor),  in_signed & divisor[DATA_W-1]));
  end

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem),
    .divisor (dsr_mag),
    .bit_in  (dvd_sh[DATA_W-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/control strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        fix_en    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd_sh   <= '0;
      rem      <= '0;
      dsr_mag  <= '0;
      dvd_orig <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      cnt      <= CNT_LOAD;
      dvd_sh   <= dvd_mag;
      rem      <= '0;
      dsr_mag  <= dsr_mag_in;
      dvd_orig <= dividend;
      sign_q   <= in_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      sign_r   <= in_signed & dividend[DATA_W-1];
      zero_q   <= (divisor == '0);
      ovf_q    <= in_signed & (dividend == MOST_NEG) & (divisor == '1);
    end else if (step_en) begin
      cnt    <= cnt - CNT_W'(1);
      rem    <= rem_nxt;
      dvd_sh <= {dvd_sh[DATA_W-2:0], q_bit};
    end
  end

  // Sign correction and zero-divisor override; results then hold through DONE.
  // Most-negative / -1 already yields quotient MOST_NEG, remainder 0, so only the flag is added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (fix_en) begin
      quotient  <= zero_q ? '1       : (sign_q ? -dvd_sh : dvd_sh);
      remainder <= zero_q ? dvd_orig : (sign_r ? -rem    : rem);
      div_zero  <= zero_q;
      overflow  <= ovf_q;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases at DATA_W=8 plus random
// back-to-back sweeps at DATA_W=32 and DATA_W=5 against an arithmetic model.
module tb_div_iter;

  logic clk;
  logic rst_n;

  logic       in_valid_8, in_ready_8, in_signed_8, out_valid_8, out_ready_8;
  logic [7:0] dividend_8, divisor_8, quotient_8, remainder_8;
  logic       div_zero_8, overflow_8;

  logic        in_valid_32, in_ready_32, in_signed_32, out_valid_32, out_ready_32;
  logic [31:0] dividend_32, divisor_32, quotient_32, remainder_32;
  logic        div_zero_32, overflow_32;

  logic       in_valid_5, in_ready_5, in_signed_5, out_valid_5, out_ready_5;
  logic [4:0] dividend_5, divisor_5, quotient_5, remainder_5;
  logic       div_zero_5, overflow_5;

  int n_assert;
  int n_fail;

  div_iter #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_8), .in_ready(in_ready_8), .in_signed(in_signed_8),
    .dividend(dividend_8), .divisor(divisor_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8),
    .quotient(quotient_8), .remainder(remainder_8),
    .div_zero(div_zero_8), .overflow(overflow_8)
  );

  div_iter #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_32), .in_ready(in_ready_32), .in_signed(in_signed_32),
    .dividend(dividend_32), .divisor(divisor_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32),
    .quotient(quotient_32), .remainder(remainder_32),
    .div_zero(div_zero_32), .overflow(overflow_32)
  );

  div_iter #(.DATA_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_5), .in_ready(in_ready_5), .in_signed(in_signed_5),
    .dividend(dividend_5), .divisor(divisor_5),
    .out_valid(out_valid_5), .out_ready(out_ready_5),
    .quotient(quotient_5), .remainder(remainder_5),
    .div_zero(div_zero_5), .overflow(overflow_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division semantics (truncate toward zero,
  // remainder takes the dividend's sign) plus the documented special cases.
  function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input bit s, output logic [63:0] q, output logic [63:0] r,
                                  output bit dz, output bit ov);
    logic [63:0] mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      q  = mask;
      r  = a;
      dz = 1'b1;
    end else if (s) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) <<< w);
      if (b[w-1]) sb = sb - (longint'(1) <<< w);
      if (sa == -(longint'(1) <<< (w - 1)) && sb == -1) begin
        q  = a;
        r  = 64'd0;
        ov = 1'b1;
      end else begin
        q = 64'(sa / sb) & mask;
        r = 64'(sa % sb) & mask;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Random operands, biased toward zero divisors and the most-negative / -1 pair.
  function automatic void pick_ops(input int w, output logic [63:0] a, output logic [63:0] b,
                                   output bit s);
    logic [63:0] mask;
    int sel;
    mask = (64'd1 << w) - 64'd1;
    sel  = int'($urandom_range(0, 7));
    s    = bit'($urandom_range(0, 1));
    a    = {32'($urandom()), 32'($urandom())} & mask;
    b    = {32'($urandom()), 32'($urandom())} & mask;
    if (sel == 0) b = 64'd0;
    if (sel == 1) begin
      s = 1'b1;
      a = 64'd1 << (w - 1);
      b = mask;
    end
    if (sel == 2) b = b & 64'h7;
  endfunction

  // Drives one operation into the 8-bit instance and returns the result plus
  // the number of cycles from the accept edge to out_valid.
  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, output int lat);
    for (int k = 0; k < 50 && in_ready_8 !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    in_signed_8 = s;
    dividend_8  = a;
    divisor_8   = b;
    in_valid_8  = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    dividend_8 = 8'h00;
    divisor_8  = 8'h00;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid_8 !== 1'b1 && lat < 100);
  endtask

  task automatic release8();
    out_ready_8 = 1'b1;
    @(posedge clk); #1;
    out_ready_8 = 1'b0;
  endtask

  task automatic test_reset();
    n_assert++;
    if (in_ready_8 !== 1'b1 || out_valid_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected 1 0", in_ready_8, out_valid_8);
    end
    n_assert++;
    if ({quotient_8, remainder_8, div_zero_8, overflow_8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_results: q=%h r=%h dz=%b ov=%b, expected all 0",
               quotient_8, remainder_8, div_zero_8, overflow_8);
    end
    n_assert++;
    if (in_ready_32 !== 1'b1 || out_valid_32 !== 1'b0 || quotient_32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_w32: in_ready=%b out_valid=%b q=%h, expected 1 0 0",
               in_ready_32, out_valid_32, quotient_32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit         s;
    logic [7:0] a, b, q, r;
    bit         dz, ov;
  } case_t;

  task automatic test_directed_8();
    case_t tc[7];
    int lat;
    tc[0] = '{1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 1'b0};
    tc[1] = '{1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0, 1'b0};
    tc[2] = '{1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0, 1'b0};
    tc[3] = '{1'b1, 8'hFB,  8'h00, 8'hFF,  8'hFB, 1'b1, 1'b0};
    tc[4] = '{1'b0, 8'h09,  8'h00, 8'hFF,  8'h09, 1'b1, 1'b0};
    tc[5] = '{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, 1'b1};
    tc[6] = '{1'b0, 8'h80,  8'hFF, 8'h00,  8'h80, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run8(tc[i].s, tc[i].a, tc[i].b, lat);
      n_assert++;
      if (lat !== 9) begin
        n_fail++;
        $display("FAIL directed%0d_latency: got %0d cycles, expected 9", i, lat);
      end
      n_assert++;
      if ({quotient_8, remainder_8, div_zero_8, overflow_8} !==
          {tc[i].q, tc[i].r, tc[i].dz, tc[i].ov}) begin
        n_fail++;
        $display("FAIL directed%0d_result: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                 i, quotient_8, remainder_8, div_zero_8, overflow_8,
                 tc[i].q, tc[i].r, tc[i].dz, tc[i].ov);
      end
      release8();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run8(1'b0, 8'd100, 8'd9, lat);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid_8  = c[0];
      in_signed_8 = 1'b0;
      dividend_8  = 8'd50;
      divisor_8   = 8'd3;
      @(posedge clk); #1;
      if (quotient_8 !== 8'd11 || remainder_8 !== 8'd1 || out_valid_8 !== 1'b1 ||
          in_ready_8 !== 1'b0) bad++;
    end
    in_valid_8 = 1'b0;
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d of 5 cycles unstable (last q=%h r=%h ov=%b rdy=%b), expected q=0b r=01 valid=1 ready=0",
               bad, quotient_8, remainder_8, out_valid_8, in_ready_8);
    end
    release8();
    n_assert++;
    if (in_ready_8 !== 1'b1 || out_valid_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, expected 1 0", in_ready_8, out_valid_8);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_assert++;
    if (in_ready_8 !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_ignored_pulses: in_ready=%b after idle cycles, expected 1", in_ready_8);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_signed_8 = 1'b0;
    dividend_8  = 8'd200;
    divisor_8   = 8'd7;
    in_valid_8  = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    n_assert++;
    if (in_ready_8 !== 1'b1 || out_valid_8 !== 1'b0 ||
        {quotient_8, remainder_8, div_zero_8, overflow_8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid_values: rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, expected 1 0 00 00 0 0",
               in_ready_8, out_valid_8, quotient_8, remainder_8, div_zero_8, overflow_8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (out_valid_8 === 1'b1) seen++;
    end
    n_assert++;
    if (seen != 0 || in_ready_8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_spurious: out_valid seen %0d times, in_ready=%b, expected 0 and 1",
               seen, in_ready_8);
    end
  endtask

  task automatic test_sweep32(input int n);
    logic [63:0] a, b, eq, er;
    bit s, edz, eov;
    int lat;
    pick_ops(32, a, b, s);
    in_signed_32 = s; dividend_32 = a[31:0]; divisor_32 = b[31:0]; in_valid_32 = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 50 && in_ready_32 !== 1'b1; k++) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid_32 = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (out_valid_32 !== 1'b1 && lat < 100);
      ref_div(32, a, b, s, eq, er, edz, eov);
      n_assert++;
      if (lat !== 33) begin
        n_fail++;
        $display("FAIL sweep32_latency op%0d: got %0d, expected 33", i, lat);
      end
      n_assert++;
      if ({quotient_32, remainder_32, div_zero_32, overflow_32} !== {eq[31:0], er[31:0], edz, eov}) begin
        n_fail++;
        $display("FAIL sweep32 op%0d s=%b %h/%h: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                 i, s, a[31:0], b[31:0], quotient_32, remainder_32, div_zero_32, overflow_32,
                 eq[31:0], er[31:0], edz, eov);
      end
      if (i < n - 1) begin
        pick_ops(32, a, b, s);
        in_signed_32 = s; dividend_32 = a[31:0]; divisor_32 = b[31:0]; in_valid_32 = 1'b1;
      end
      out_ready_32 = 1'b1;
      @(posedge clk); #1;
      out_ready_32 = 1'b0;
      if (i < n - 1) begin
        n_assert++;
        if (in_ready_32 !== 1'b1 || out_valid_32 !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep32_reaccept op%0d: in_ready=%b out_valid=%b, expected 1 0",
                   i, in_ready_32, out_valid_32);
        end
      end
    end
  endtask

  task automatic test_sweep5(input int n);
    logic [63:0] a, b, eq, er;
    bit s, edz, eov;
    int lat;
    pick_ops(5, a, b, s);
    in_signed_5 = s; dividend_5 = a[4:0]; divisor_5 = b[4:0]; in_valid_5 = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 50 && in_ready_5 !== 1'b1; k++) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid_5 = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (out_valid_5 !== 1'b1 && lat < 100);
      ref_div(5, a, b, s, eq, er, edz, eov);
      n_assert++;
      if (lat !== 6) begin
        n_fail++;
        $display("FAIL sweep5_latency op%0d: got %0d, expected 6", i, lat);
      end
      n_assert++;
      if ({quotient_5, remainder_5, div_zero_5, overflow_5} !== {eq[4:0], er[4:0], edz, eov}) begin
        n_fail++;
        $display("FAIL sweep5 op%0d s=%b %h/%h: got q=%h r=%h dz=%b ov=%b, expected q=%h r=%h dz=%b ov=%b",
                 i, s, a[4:0], b[4:0], quotient_5, remainder_5, div_zero_5, overflow_5,
                 eq[4:0], er[4:0], edz, eov);
      end
      if (i < n - 1) begin
        pick_ops(5, a, b, s);
        in_signed_5 = s; dividend_5 = a[4:0]; divisor_5 = b[4:0]; in_valid_5 = 1'b1;
      end
      out_ready_5 = 1'b1;
      @(posedge clk); #1;
      out_ready_5 = 1'b0;
      if (i < n - 1) begin
        n_assert++;
        if (in_ready_5 !== 1'b1 || out_valid_5 !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep5_reaccept op%0d: in_ready=%b out_valid=%b, expected 1 0",
                   i, in_ready_5, out_valid_5);
        end
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    in_valid_8 = 1'b0;  in_signed_8 = 1'b0;  dividend_8 = '0;  divisor_8 = '0;  out_ready_8 = 1'b0;
    in_valid_32 = 1'b0; in_signed_32 = 1'b0; dividend_32 = '0; divisor_32 = '0; out_ready_32 = 1'b0;
    in_valid_5 = 1'b0;  in_signed_5 = 1'b0;  dividend_5 = '0;  divisor_5 = '0;  out_ready_5 = 1'b0;
    #23;
    test_reset();
    test_directed_8();
    test_backpressure();
    test_reset_mid();
    test_sweep32(40);
    test_sweep5(80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
